task_msg_checker: RTL and testbench

TASK_MSG_CHECKER -- requirements
Module: task_msg_checker

---
 rtl/task_msg_checker_if.sv | 32 +++
 rtl/task_msg_checker.sv | 228 ++++++++++++++++++++++
 tb/tb_task_msg_checker.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/task_msg_checker_if.sv
// Handshake bundle for task_msg_checker: inbound words (s_*), forwarded payload (m_*), verdict (v_*).
// The slave modport is the checker's view; the master modport is the view of whatever drives it.
interface task_msg_checker_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;

    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    logic        v_valid;
    logic        v_ready;
    logic [31:0] v_status;
    logic [31:0] v_len;
    logic [31:0] v_seq_id;
    logic [7:0]  v_task_id;

    modport slave (
        input  s_data, s_valid, s_last, m_ready, v_ready,
        output s_ready, m_data, m_valid, m_last,
        output v_valid, v_status, v_len, v_seq_id, v_task_id
    );

    modport master (
        output s_data, s_valid, s_last, m_ready, v_ready,
        input  s_ready, m_data, m_valid, m_last,
        input  v_valid, v_status, v_len, v_seq_id, v_task_id
    );
endinterface

// File: rtl/task_msg_checker.sv
// Task message checker: validates a header, forwards the payload, and emits one verdict per message.
// Define TASK_MSG_SEQ_CHECK_EN to also require SEQ_ID to follow the last accepted TASK_VALID SEQ_ID.
module task_msg_checker #(
    parameter int MAX_MSG_WORDS = 12,
    parameter int HEADER_WORDS  = 4,
    parameter int TASK_ID_LO    = 100,
    parameter int TASK_ID_HI    = 101
) (
    input  logic                clk,
    input  logic                rst,
    task_msg_checker_if.slave   bus
);

    localparam int CW = $clog2(MAX_MSG_WORDS + 1);

    localparam logic [CW-1:0] IDX_LEN   = CW'(0);
    localparam logic [CW-1:0] IDX_SEQ   = CW'(1);
    localparam logic [CW-1:0] IDX_TASK  = CW'(2);
    localparam logic [CW-1:0] IDX_STAT  = CW'(3);
    localparam logic [CW-1:0] HDR_LAST  = CW'(HEADER_WORDS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_MSG_WORDS);
    localparam logic [7:0]    ID_LO     = 8'(TASK_ID_LO);
    localparam logic [7:0]    ID_HI     = 8'(TASK_ID_HI);

    typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN, VERDICT} state_e;
    typedef enum logic [1:0] {
        TASK_VALID      = 2'd0,
        HEADER_INVALID  = 2'd1,
        PAYLOAD_INVALID = 2'd2
    } status_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   seq_q, seq_d;
    logic [31:0]   task_q, task_d;
    logic [31:0]   stat_q, stat_d;
    status_e       verdict_q, verdict_d;

    logic          s_accept;
    logic          last_idx;
    logic          len_is_hdr;
    logic [31:0]   stat_eff;
    logic          seq_ok;
    logic          hdr_ok;

`ifdef TASK_MSG_SEQ_CHECK_EN
    logic          ref_valid_q, ref_valid_d;
    logic [31:0]   ref_seq_q, ref_seq_d;

    // No reference until the first TASK_VALID verdict has been handed off.
    assign seq_ok = !ref_valid_q || (seq_q == ref_seq_q + 32'd1);
`else
    assign seq_ok = 1'b1;
`endif

    // Acceptance is derived from state rather than from the s_ready output to keep it reset-independent.
    assign s_accept   = bus.s_valid &&
                        ((state_q == PAYLOAD) ? bus.m_ready : (state_q == HDR || state_q == DRAIN));
    assign last_idx   = (32'(cnt_q) == len_q - 32'd1);
    assign len_is_hdr = (len_q == 32'(HEADER_WORDS));
    // With a 4-word header STATUS arrives in the very word that triggers the check.
    assign stat_eff   = (cnt_q == IDX_STAT) ? bus.s_data : stat_q;
    assign hdr_ok     = (len_q >= 32'(HEADER_WORDS)) && (len_q <= 32'(MAX_MSG_WORDS)) &&
                        (task_q[7:0] >= ID_LO) && (task_q[7:0] <= ID_HI) &&
                        (task_q[31:8] == 24'd0) && (stat_eff == 32'd0) && seq_ok;

    // NOTE: asynchronous reset belongs in the sensitivity list; sequential state uses <= only
    // so every flop samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            seq_q       <= '0;
            task_q      <= '0;
            stat_q      <= '0;
            verdict_q   <= TASK_VALID;
`ifdef TASK_MSG_SEQ_CHECK_EN
            ref_valid_q <= 1'b0;
            ref_seq_q   <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            task_q      <= task_d;
            stat_q      <= stat_d;
            verdict_q   <= verdict_d;
`ifdef TASK_MSG_SEQ_CHECK_EN
            ref_valid_q <= ref_valid_d;
            ref_seq_q   <= ref_seq_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        seq_d     = seq_q;
        task_d    = task_q;
        stat_d    = stat_q;
        verdict_d = verdict_q;
`ifdef TASK_MSG_SEQ_CHECK_EN
        ref_valid_d = ref_valid_q;
        ref_seq_d   = ref_seq_q;
`endif

        if (s_accept && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        unique case (state_q)
            HDR: begin
                if (s_accept) begin
                    if (cnt_q == IDX_LEN)  len_d  = bus.s_data;
                    if (cnt_q == IDX_SEQ)  seq_d  = bus.s_data;
                    if (cnt_q == IDX_TASK) task_d = bus.s_data;
                    if (cnt_q == IDX_STAT) stat_d = bus.s_data;

                    if (cnt_q == HDR_LAST) begin
                        if (!hdr_ok) begin
                            state_d   = bus.s_last ? VERDICT : DRAIN;
                            verdict_d = HEADER_INVALID;
                        end else if (bus.s_last) begin
                            state_d   = VERDICT;
                            verdict_d = len_is_hdr ? TASK_VALID : PAYLOAD_INVALID;
                        end else if (len_is_hdr) begin
                            state_d   = DRAIN;
                            verdict_d = PAYLOAD_INVALID;
                        end else begin
                            state_d   = PAYLOAD;
                        end
                    end else if (bus.s_last) begin
                        state_d   = VERDICT;
                        verdict_d = HEADER_INVALID;
                    end
                end
            end

            PAYLOAD: begin
                if (s_accept) begin
                    if (last_idx && bus.s_last) begin
                        state_d   = VERDICT;
                        verdict_d = TASK_VALID;
                    end else if (bus.s_last) begin
                        state_d   = VERDICT;
                        verdict_d = PAYLOAD_INVALID;
                    end else if (last_idx) begin
                        state_d   = DRAIN;
                        verdict_d = PAYLOAD_INVALID;
                    end
                end
            end

            DRAIN: begin
                if (s_accept && bus.s_last) begin
                    state_d = VERDICT;
                end
            end

            VERDICT: begin
                if (bus.v_ready) begin
                    state_d   = HDR;
                    cnt_d     = '0;
                    len_d     = '0;
                    seq_d     = '0;
                    task_d    = '0;
                    stat_d    = '0;
                    verdict_d = TASK_VALID;
`ifdef TASK_MSG_SEQ_CHECK_EN
                    if (verdict_q == TASK_VALID) begin
                        ref_valid_d = 1'b1;
                        ref_seq_d   = seq_q;
                    end
`endif
                end
            end

            default: state_d = HDR;
        endcase
    end

    always_comb begin
        bus.s_ready   = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_data    = '0;
        bus.m_last    = 1'b0;
        bus.v_valid   = 1'b0;
        bus.v_status  = '0;
        bus.v_len     = '0;
        bus.v_seq_id  = '0;
        bus.v_task_id = '0;

        // Outputs are forced quiet for the whole time reset is held, not just after the edge.
        if (!rst) begin
            unique case (state_q)
                HDR, DRAIN: begin
                    bus.s_ready = 1'b1;
                end
                PAYLOAD: begin
                    bus.s_ready = bus.m_ready;
                    bus.m_valid = bus.s_valid;
                    bus.m_data  = bus.s_data;
                    bus.m_last  = bus.s_last || last_idx;
                end
                VERDICT: begin
                    bus.v_valid   = 1'b1;
                    bus.v_status  = {30'd0, verdict_q};
                    bus.v_len     = len_q;
                    bus.v_seq_id  = seq_q;
                    bus.v_task_id = task_q[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_task_msg_checker.sv
// Directed bench for task_msg_checker; every expected value is a hand-computed constant.
// Seq-check expectations follow TASK_MSG_SEQ_CHECK_EN when the bench is built with it defined.
module tb_task_msg_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    task_msg_checker_if bus_if();

    task_msg_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

`ifdef TASK_MSG_SEQ_CHECK_EN
    localparam logic [31:0] SEQ_GAP_STATUS = 32'd1;
`else
    localparam logic [31:0] SEQ_GAP_STATUS = 32'd0;
`endif

    typedef struct {
        logic [31:0] len;
        logic [31:0] seq;
        logic [31:0] tsk;
        logic [31:0] stat;
        logic [31:0] exp_status;
        logic [31:0] exp_task;
    } hdr_case_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic        obs_mv;
    logic        obs_ml;
    logic [31:0] obs_md;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_ready"},  32'(bus_if.s_ready),   32'd0);
        check({tag, "_m_valid"},  32'(bus_if.m_valid),   32'd0);
        check({tag, "_m_last"},   32'(bus_if.m_last),    32'd0);
        check({tag, "_m_data"},   bus_if.m_data,         32'd0);
        check({tag, "_v_valid"},  32'(bus_if.v_valid),   32'd0);
        check({tag, "_v_status"}, bus_if.v_status,       32'd0);
        check({tag, "_v_len"},    bus_if.v_len,          32'd0);
        check({tag, "_v_seq"},    bus_if.v_seq_id,       32'd0);
        check({tag, "_v_task"},   32'(bus_if.v_task_id), 32'd0);
    endtask

    task automatic apply_reset();
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
        bus_if.s_data  = '0;
        bus_if.m_ready = 1'b1;
        bus_if.v_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Presents one word, waits (bounded) for s_ready, and records the m_* view just before the edge.
    task automatic send_word(input logic [31:0] d, input logic last);
        int waited = 0;
        bus_if.s_data  = d;
        bus_if.s_last  = last;
        bus_if.s_valid = 1'b1;
        #1;
        while (!bus_if.s_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!bus_if.s_ready) check("s_ready_timeout", 32'd0, 32'd1);
        obs_mv = bus_if.m_valid;
        obs_ml = bus_if.m_last;
        obs_md = bus_if.m_data;
        step();
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
        bus_if.s_data  = '0;
    endtask

    task automatic send_header(input logic [31:0] len, input logic [31:0] seq,
                               input logic [31:0] tsk, input logic [31:0] stat, input logic last);
        send_word(len, 1'b0);
        send_word(seq, 1'b0);
        send_word(tsk, 1'b0);
        send_word(stat, last);
    endtask

    // Called right after the final word's edge: the verdict must already be up.
    task automatic expect_verdict(input string tag, input logic [31:0] status, input logic [31:0] len,
                                  input logic [31:0] seq, input logic [31:0] tsk);
        check({tag, "_v_valid"},  32'(bus_if.v_valid),   32'd1);
        check({tag, "_v_status"}, bus_if.v_status,       status);
        check({tag, "_v_len"},    bus_if.v_len,          len);
        check({tag, "_v_seq"},    bus_if.v_seq_id,       seq);
        check({tag, "_v_task"},   32'(bus_if.v_task_id), tsk);
        bus_if.v_ready = 1'b1;
        step();
        bus_if.v_ready = 1'b0;
        check({tag, "_v_drop"},   32'(bus_if.v_valid),   32'd0);
        check({tag, "_v_zero"},   bus_if.v_status | bus_if.v_len | bus_if.v_seq_id, 32'd0);
        check({tag, "_hdr_rdy"},  32'(bus_if.s_ready),   32'd1);
    endtask

    hdr_case_t hdr_cases [9] = '{
        '{32'd4,  32'd1, 32'd100,   32'd0, 32'd0, 32'd100},
        '{32'd4,  32'd1, 32'd101,   32'd0, 32'd0, 32'd101},
        '{32'd4,  32'd1, 32'd99,    32'd0, 32'd1, 32'd99},
        '{32'd4,  32'd1, 32'd102,   32'd0, 32'd1, 32'd102},
        '{32'd4,  32'd1, 32'h164,   32'd0, 32'd1, 32'h64},
        '{32'd4,  32'd1, 32'd100,   32'd5, 32'd1, 32'd100},
        '{32'd3,  32'd1, 32'd100,   32'd0, 32'd1, 32'd100},
        '{32'd13, 32'd1, 32'd100,   32'd0, 32'd1, 32'd100},
        '{32'd5,  32'd1, 32'd100,   32'd0, 32'd2, 32'd100}
    };

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
        bus_if.s_data  = '0;
        bus_if.m_ready = 1'b1;
        bus_if.v_ready = 1'b0;
        rst = 1'b1;
        step();
        check_quiet("rst_hold");
        rst = 1'b0;
        #1;
        check("rst_release_s_ready", 32'(bus_if.s_ready), 32'd1);

        // Good message with two payload words, plus a backpressure stall on the first.
        send_header(32'd6, 32'd7, 32'd100, 32'd0, 1'b0);
        check("t1_hdr_no_m_valid", 32'(obs_mv), 32'd0);
        bus_if.s_data  = 32'hA0A0_0001;
        bus_if.s_valid = 1'b1;
        bus_if.m_ready = 1'b0;
        #1;
        check("t1_bp_s_ready", 32'(bus_if.s_ready), 32'd0);
        check("t1_bp_m_valid", 32'(bus_if.m_valid), 32'd1);
        step();
        bus_if.m_ready = 1'b1;
        send_word(32'hA0A0_0001, 1'b0);
        check("t1_p0_m_valid", 32'(obs_mv), 32'd1);
        check("t1_p0_m_data",  obs_md,      32'hA0A0_0001);
        check("t1_p0_m_last",  32'(obs_ml), 32'd0);
        send_word(32'hB0B0_0002, 1'b1);
        check("t1_p1_m_data",  obs_md,      32'hB0B0_0002);
        check("t1_p1_m_last",  32'(obs_ml), 32'd1);
        expect_verdict("t1", 32'd0, 32'd6, 32'd7, 32'd100);

        // Bad task id: drained word never shows on m_*.
        apply_reset();
        send_header(32'd5, 32'd1, 32'd102, 32'd0, 1'b0);
        send_word(32'h1111_1111, 1'b1);
        check("t2_drain_m_valid", 32'(obs_mv), 32'd0);
        expect_verdict("t2", 32'd1, 32'd5, 32'd1, 32'd102);

        // Early s_last in payload.
        apply_reset();
        send_header(32'd8, 32'd2, 32'd101, 32'd0, 1'b0);
        send_word(32'h2222_0000, 1'b0);
        check("t3_p0_m_last", 32'(obs_ml), 32'd0);
        send_word(32'h2222_0001, 1'b1);
        check("t3_p1_m_last", 32'(obs_ml), 32'd1);
        expect_verdict("t3", 32'd2, 32'd8, 32'd2, 32'd101);

        // LEN reached without s_last, then two extra words drained.
        apply_reset();
        send_header(32'd5, 32'd3, 32'd100, 32'd0, 1'b0);
        send_word(32'h3333_0000, 1'b0);
        check("t4_p0_m_valid", 32'(obs_mv), 32'd1);
        check("t4_p0_m_last",  32'(obs_ml), 32'd1);
        send_word(32'h3333_0001, 1'b0);
        check("t4_x0_m_valid", 32'(obs_mv), 32'd0);
        send_word(32'h3333_0002, 1'b1);
        check("t4_x1_m_valid", 32'(obs_mv), 32'd0);
        expect_verdict("t4", 32'd2, 32'd5, 32'd3, 32'd100);

        // s_last on header word 1.
        apply_reset();
        send_word(32'd4, 1'b0);
        send_word(32'd11, 1'b1);
        expect_verdict("t5_short_hdr", 32'd1, 32'd4, 32'd11, 32'd0);

        // Longest legal message: 4 header + 8 payload words.
        apply_reset();
        send_header(32'd12, 32'd4, 32'd100, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) send_word(32'h4000_0000 + 32'(i), i == 7);
        check("t6_max_m_last", 32'(obs_ml), 32'd1);
        check("t6_max_m_data", obs_md, 32'h4000_0007);
        expect_verdict("t6_max", 32'd0, 32'd12, 32'd4, 32'd100);

        // Header field boundaries, each message ending on header word 3.
        foreach (hdr_cases[i]) begin
            apply_reset();
            send_header(hdr_cases[i].len, hdr_cases[i].seq, hdr_cases[i].tsk, hdr_cases[i].stat, 1'b1);
            expect_verdict($sformatf("t7_case%0d", i), hdr_cases[i].exp_status,
                           hdr_cases[i].len, hdr_cases[i].seq, hdr_cases[i].exp_task);
        end

        // Verdict held off for 5 cycles.
        apply_reset();
        send_header(32'd4, 32'd10, 32'd101, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t8_hold%0d_v_valid", i), 32'(bus_if.v_valid),   32'd1);
            check($sformatf("t8_hold%0d_status", i),  bus_if.v_status,       32'd0);
            check($sformatf("t8_hold%0d_len", i),     bus_if.v_len,          32'd4);
            check($sformatf("t8_hold%0d_seq", i),     bus_if.v_seq_id,       32'd10);
            check($sformatf("t8_hold%0d_task", i),    32'(bus_if.v_task_id), 32'd101);
            check($sformatf("t8_hold%0d_s_ready", i), 32'(bus_if.s_ready),   32'd0);
            step();
        end
        expect_verdict("t8", 32'd0, 32'd4, 32'd10, 32'd101);

        // Reset in the middle of payload word 1.
        apply_reset();
        send_header(32'd6, 32'd20, 32'd100, 32'd0, 1'b0);
        send_word(32'h5555_0000, 1'b0);
        bus_if.s_data  = 32'h5555_0001;
        bus_if.s_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_quiet("t9_mid_rst");
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = '0;
        step();
        rst = 1'b0;
        #1;
        send_header(32'd4, 32'd9, 32'd100, 32'd0, 1'b1);
        expect_verdict("t9_after_rst", 32'd0, 32'd4, 32'd9, 32'd100);

        // Sequence continuity: 5 good, 7 skips a value, 6 follows 5.
        apply_reset();
        send_header(32'd4, 32'd5, 32'd100, 32'd0, 1'b1);
        expect_verdict("t10_seq5", 32'd0, 32'd4, 32'd5, 32'd100);
        send_header(32'd4, 32'd7, 32'd100, 32'd0, 1'b1);
        expect_verdict("t10_seq7", SEQ_GAP_STATUS, 32'd4, 32'd7, 32'd100);
        send_header(32'd4, 32'd6, 32'd100, 32'd0, 1'b1);
        expect_verdict("t10_seq6", 32'd0, 32'd4, 32'd6, 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
